speicher_arbiter: RTL and testbench

Two-port arbiter that shares one word-addressed RAM between the instruction cache miss port and the data cache miss port. It sits between the caches' RAM-side interfaces (`RAMLesen`/`RAMSchreiben`/`RAMAdresse`/`RAMSchreibDaten`) and a single `RAM` instance, which lets instruction and data live in one unified memory. Requests are serialised with round-robin priority and registered forwarding, and each access is guarded by a response watchdog.

---
 rtl/speicher_pkg.sv | 31 +++
 rtl/speicher_watchdog.sv | 25 ++
 rtl/speicher_arbiter.sv | 140 ++++++++++++++
 tb/tb_speicher_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/speicher_pkg.sv
// Shared encodings for the unified-memory arbiter and its helper blocks.
package speicher_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ZUGRIFF  = 2'd1,
    S_FERTIG   = 2'd2,
    S_FREIGABE = 2'd3
  } zustand_t;

  typedef enum logic {
    OP_LESEN     = 1'b0,
    OP_SCHREIBEN = 1'b1
  } op_t;

  localparam logic QUELLE_I = 1'b0;
  localparam logic QUELLE_D = 1'b1;

  // Round robin: on a tie the side that was not served last wins.
  function automatic logic waehleQuelle(input logic iAnfrage, input logic dAnfrage,
                                        input logic letzterD);
    if (iAnfrage && dAnfrage) return letzterD ? QUELLE_I : QUELLE_D;
    return dAnfrage ? QUELLE_D : QUELLE_I;
  endfunction

  // A side raising both strobes is treated as a write.
  function automatic op_t waehleOp(input logic schreiben);
    return schreiben ? OP_SCHREIBEN : OP_LESEN;
  endfunction

endpackage

// File: rtl/speicher_watchdog.sv
// Response watchdog: counts enabled cycles and flags the cycle in which the
// count would reach TIMEOUT. TIMEOUT = 0 never expires.
module speicher_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic Clock,
  input  logic Reset,
  input  logic loeschen,
  input  logic zaehlen,
  output logic abgelaufen
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] GRENZE = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] zaehler;

  assign abgelaufen = (TIMEOUT != 0) && zaehlen && (zaehler == GRENZE);

  always_ff @(posedge Clock) begin
    if (Reset || loeschen)          zaehler <= '0;
    else if (zaehlen && !abgelaufen) zaehler <= zaehler + CW'(1);
  end

endmodule

// File: rtl/speicher_arbiter.sv
// Serialises instruction- and data-cache miss traffic onto one word RAM with
// round-robin priority, registered RAM signals and a response watchdog.
module speicher_arbiter
  import speicher_pkg::*;
#(
  parameter int WORDSIZE   = 32,
  parameter int ADRESSBITS = 15,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  Clock,
  input  logic                  Reset,

  input  logic                  ILesen,
  input  logic                  ISchreiben,
  input  logic [31:0]           IAdresse,
  input  logic [WORDSIZE-1:0]   ISchreibDaten,
  output logic [WORDSIZE-1:0]   ILesDaten,
  output logic                  IGelesen,
  output logic                  IGeschrieben,

  input  logic                  DLesen,
  input  logic                  DSchreiben,
  input  logic [31:0]           DAdresse,
  input  logic [WORDSIZE-1:0]   DSchreibDaten,
  output logic [WORDSIZE-1:0]   DLesDaten,
  output logic                  DGelesen,
  output logic                  DGeschrieben,

  output logic                  RAMLesen,
  output logic                  RAMSchreiben,
  output logic [ADRESSBITS-1:0] RAMAdresse,
  output logic [WORDSIZE-1:0]   RAMSchreibDaten,
  input  logic [WORDSIZE-1:0]   RAMLesDaten,
  input  logic                  RAMDatenGelesen,
  input  logic                  RAMDatenGeschrieben,

  output logic                  Fehler
);

  zustand_t zustand;
  op_t      op;
  logic     quelle;
  logic     letzterD;
  logic     abgelaufen;

  logic                  iAnfrage, dAnfrage;
  logic                  quelleNeu;
  op_t                   opNeu;
  logic [ADRESSBITS-1:0] adrNeu;
  logic [WORDSIZE-1:0]   datenNeu;
  logic                  treffer;
  logic [WORDSIZE-1:0]   erfasst;
  logic                  unusedAdrBits;

  assign iAnfrage  = ILesen || ISchreiben;
  assign dAnfrage  = DLesen || DSchreiben;
  assign quelleNeu = waehleQuelle(iAnfrage, dAnfrage, letzterD);
  assign opNeu     = waehleOp((quelleNeu == QUELLE_D) ? DSchreiben : ISchreiben);
  assign adrNeu    = (quelleNeu == QUELLE_D) ? DAdresse[ADRESSBITS-1:0]
                                             : IAdresse[ADRESSBITS-1:0];
  assign datenNeu  = (quelleNeu == QUELLE_D) ? DSchreibDaten : ISchreibDaten;

  // Upper requester address bits are outside the RAM and intentionally dropped.
  assign unusedAdrBits = ^{IAdresse, DAdresse};

  // Only a done pulse matching the pending op ends the access.
  assign treffer = (op == OP_LESEN)     ? RAMDatenGelesen
                                        : RAMDatenGeschrieben;
  assign erfasst = treffer ? RAMLesDaten : '0;

  speicher_watchdog #(.TIMEOUT(TIMEOUT)) uWatchdog (
    .Clock      (Clock),
    .Reset      (Reset),
    .loeschen   (zustand != S_ZUGRIFF),
    .zaehlen    (zustand == S_ZUGRIFF),
    .abgelaufen (abgelaufen)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand         <= S_IDLE;
      op              <= OP_LESEN;
      quelle          <= QUELLE_I;
      letzterD        <= 1'b0;
      Fehler          <= 1'b0;
      RAMLesen        <= 1'b0;
      RAMSchreiben    <= 1'b0;
      RAMAdresse      <= '0;
      RAMSchreibDaten <= '0;
      ILesDaten       <= '0;
      DLesDaten       <= '0;
      IGelesen        <= 1'b0;
      IGeschrieben    <= 1'b0;
      DGelesen        <= 1'b0;
      DGeschrieben    <= 1'b0;
    end else begin
      IGelesen     <= 1'b0;
      IGeschrieben <= 1'b0;
      DGelesen     <= 1'b0;
      DGeschrieben <= 1'b0;
      case (zustand)
        S_IDLE: begin
          if (iAnfrage || dAnfrage) begin
            quelle          <= quelleNeu;
            op              <= opNeu;
            RAMLesen        <= (opNeu == OP_LESEN);
            RAMSchreiben    <= (opNeu == OP_SCHREIBEN);
            RAMAdresse      <= adrNeu;
            RAMSchreibDaten <= datenNeu;
            zustand         <= S_ZUGRIFF;
          end
        end
        S_ZUGRIFF: begin
          // A timed-out read still completes, with zero data, so the cache never hangs.
          if (treffer || abgelaufen) begin
            RAMLesen     <= 1'b0;
            RAMSchreiben <= 1'b0;
            if (op == OP_LESEN) begin
              if (quelle == QUELLE_D) DLesDaten <= erfasst;
              else                    ILesDaten <= erfasst;
            end
            if (!treffer) Fehler <= 1'b1;
            zustand <= S_FERTIG;
          end
        end
        S_FERTIG: begin
          IGelesen     <= (quelle == QUELLE_I) && (op == OP_LESEN);
          IGeschrieben <= (quelle == QUELLE_I) && (op == OP_SCHREIBEN);
          DGelesen     <= (quelle == QUELLE_D) && (op == OP_LESEN);
          DGeschrieben <= (quelle == QUELLE_D) && (op == OP_SCHREIBEN);
          letzterD     <= (quelle == QUELLE_D);
          zustand      <= S_FREIGABE;
        end
        S_FREIGABE: zustand <= S_IDLE;
        default:    zustand <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_speicher_arbiter.sv
// Bench for speicher_arbiter: RAM responder plus a transaction-level model
// predicting grant order, done timing, pulse kind and read data.
module tb_speicher_arbiter;
  localparam int WS = 32;
  localparam int AB = 15;
  localparam int TO = 8;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic          Reset;
  logic          ILesen, ISchreiben, DLesen, DSchreiben;
  logic [31:0]   IAdresse, DAdresse;
  logic [WS-1:0] ISchreibDaten, DSchreibDaten, ILesDaten, DLesDaten;
  logic          IGelesen, IGeschrieben, DGelesen, DGeschrieben;
  logic          RAMLesen, RAMSchreiben;
  logic [AB-1:0] RAMAdresse;
  logic [WS-1:0] RAMSchreibDaten;
  logic [WS-1:0] RAMLesDaten = '0;
  logic          RAMDatenGelesen = 1'b0, RAMDatenGeschrieben = 1'b0;
  logic          Fehler;

  speicher_arbiter #(.WORDSIZE(WS), .ADRESSBITS(AB), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset(Reset),
    .ILesen(ILesen), .ISchreiben(ISchreiben), .IAdresse(IAdresse),
    .ISchreibDaten(ISchreibDaten), .ILesDaten(ILesDaten),
    .IGelesen(IGelesen), .IGeschrieben(IGeschrieben),
    .DLesen(DLesen), .DSchreiben(DSchreiben), .DAdresse(DAdresse),
    .DSchreibDaten(DSchreibDaten), .DLesDaten(DLesDaten),
    .DGelesen(DGelesen), .DGeschrieben(DGeschrieben),
    .RAMLesen(RAMLesen), .RAMSchreiben(RAMSchreiben), .RAMAdresse(RAMAdresse),
    .RAMSchreibDaten(RAMSchreibDaten), .RAMLesDaten(RAMLesDaten),
    .RAMDatenGelesen(RAMDatenGelesen), .RAMDatenGeschrieben(RAMDatenGeschrieben),
    .Fehler(Fehler)
  );

  wire [3:0] pulse = {IGelesen, IGeschrieben, DGelesen, DGeschrieben};

  int zyklus = 0;
  always @(posedge Clock) zyklus <= zyklus + 1;

  // RAM responder: done pulse 'ramLat' cycles after it first sees a strobe,
  // optionally preceded by one pulse of the wrong kind.
  logic [WS-1:0] ramMem [0:(1<<AB)-1];
  int ramLat = 1, ramCnt = 0;
  bit ramStumm = 0, ramFalsch = 0, ramFertig = 0, ramFalschAus = 0;
  always @(posedge Clock) begin
    RAMDatenGelesen     <= 1'b0;
    RAMDatenGeschrieben <= 1'b0;
    RAMLesDaten         <= $urandom();
    if (!(RAMLesen || RAMSchreiben)) begin
      ramCnt <= 0; ramFertig <= 0; ramFalschAus <= 0;
    end else if (!ramFertig && !ramStumm) begin
      if (ramCnt + 1 >= ramLat) begin
        if (ramFalsch && !ramFalschAus) begin
          ramFalschAus <= 1;
          if (RAMSchreiben) RAMDatenGelesen <= 1'b1;
          else              RAMDatenGeschrieben <= 1'b1;
        end else begin
          ramFertig <= 1;
          if (RAMSchreiben) begin
            ramMem[RAMAdresse]  <= RAMSchreibDaten;
            RAMDatenGeschrieben <= 1'b1;
          end else begin
            RAMLesDaten     <= ramMem[RAMAdresse];
            RAMDatenGelesen <= 1'b1;
          end
        end
      end else ramCnt <= ramCnt + 1;
    end
  end

  typedef struct {
    bit          lesen;
    bit          schreiben;
    logic [31:0] adr;
    logic [31:0] daten;
  } req_t;

  int checks = 0, failures = 0;
  bit refLetzterD = 0, refFehler = 0;
  int refFrei = 0;
  logic [WS-1:0] refMem [int];
  int bedient [$];

  task automatic pruefe(input string tag, input logic [63:0] ist, input logic [63:0] soll);
    checks++;
    assert (ist === soll) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, ist, soll);
    end
  endtask

  function automatic req_t mk(input bit l, input bit s, input logic [31:0] a, input logic [31:0] d);
    req_t r;
    r.lesen = l; r.schreiben = s; r.adr = a; r.daten = d;
    return r;
  endfunction

  function automatic req_t zufall();
    int o;
    o = $urandom_range(0, 2);
    return mk(o != 1, o != 0, ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 15)), $urandom());
  endfunction

  // Presents both requests together, then follows each predicted access to its done pulse.
  task automatic runde(input req_t ri, input req_t rd, input int lat, input bit stumm,
                       input bit falsch, input string tag);
    int reihe [$];
    req_t r;
    int s, G, T, R, strobeZyk;
    bit schreib, strobeOk, gesehen;
    logic [AB-1:0] a;
    logic [WS-1:0] sollDaten;
    logic [3:0] sollPuls;
    ramLat = lat; ramStumm = stumm; ramFalsch = falsch;
    ILesen = ri.lesen; ISchreiben = ri.schreiben; IAdresse = ri.adr; ISchreibDaten = ri.daten;
    DLesen = rd.lesen; DSchreiben = rd.schreiben; DAdresse = rd.adr; DSchreibDaten = rd.daten;
    R = zyklus + 1;
    if ((ri.lesen || ri.schreiben) && (rd.lesen || rd.schreiben)) begin
      if (refLetzterD) begin reihe.push_back(0); reihe.push_back(1); end
      else             begin reihe.push_back(1); reihe.push_back(0); end
    end else if (ri.lesen || ri.schreiben) reihe.push_back(0);
    else if (rd.lesen || rd.schreiben)     reihe.push_back(1);
    for (int k = 0; k < reihe.size(); k++) begin
      s = reihe[k];
      r = (s != 0) ? rd : ri;
      schreib = r.schreiben;
      a = r.adr[AB-1:0];
      G = (R > refFrei) ? R : refFrei;
      T = stumm ? G + 1 + TO : G + 2 + lat + int'(falsch);
      sollPuls = (s != 0) ? (schreib ? 4'b0001 : 4'b0010) : (schreib ? 4'b0100 : 4'b1000);
      sollDaten = (stumm || !refMem.exists(int'(a))) ? '0 : refMem[int'(a)];
      strobeOk = 1; strobeZyk = 0; gesehen = 0;
      for (int n = 0; n < 200 && !gesehen; n++) begin
        @(negedge Clock);
        if (RAMLesen || RAMSchreiben) begin
          strobeZyk++;
          if (RAMAdresse !== a || RAMSchreiben !== schreib || RAMLesen !== !schreib ||
              (schreib && RAMSchreibDaten !== r.daten)) strobeOk = 0;
        end
        if (pulse != 4'b0) gesehen = 1;
      end
      pruefe({tag, " fertig"}, gesehen, 1);
      if (!gesehen) return;
      pruefe({tag, " puls"}, pulse, sollPuls);
      pruefe({tag, " zeit"}, zyklus, T);
      pruefe({tag, " ramsignale"}, strobeOk, 1);
      pruefe({tag, " strobedauer"}, strobeZyk, stumm ? TO : lat + 1 + int'(falsch));
      if (!schreib) pruefe({tag, " lesdaten"}, (s != 0) ? DLesDaten : ILesDaten, sollDaten);
      refFehler = refFehler | stumm;
      pruefe({tag, " fehler"}, Fehler, refFehler);
      if (schreib && !stumm) refMem[int'(a)] = r.daten;
      refLetzterD = (s != 0);
      refFrei = zyklus + 2;
      bedient.push_back(s);
      if (s != 0) begin DLesen = 0; DSchreiben = 0; end
      else        begin ILesen = 0; ISchreiben = 0; end
      @(negedge Clock);
      pruefe({tag, " pulsbreite"}, pulse, 4'b0);
    end
  endtask

  task automatic resetPuls();
    @(negedge Clock);
    Reset = 1; ILesen = 0; ISchreiben = 0; DLesen = 0; DSchreiben = 0;
    repeat (2) @(negedge Clock);
    Reset = 0;
    refLetzterD = 0; refFehler = 0; refFrei = zyklus + 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  req_t keine;
  logic [5:0] folge;
  int w;

  initial begin
    keine = mk(0, 0, 0, 0);
    Reset = 1; ILesen = 0; ISchreiben = 0; DLesen = 0; DSchreiben = 0;
    IAdresse = 0; DAdresse = 0; ISchreibDaten = 0; DSchreibDaten = 0;
    for (int i = 0; i < (1 << AB); i++) ramMem[i] = '0;
    ramMem[5] = 32'hDEADBEEF;
    refMem[5] = 32'hDEADBEEF;
    repeat (3) @(negedge Clock);
    pruefe("reset strobes", {RAMLesen, RAMSchreiben, pulse, Fehler}, 7'b0);
    pruefe("reset adresse", RAMAdresse, 0);
    pruefe("reset lesdaten", {ILesDaten, DLesDaten}, 64'b0);
    Reset = 0;
    refFrei = zyklus + 1;

    runde(keine, mk(1, 0, 32'h5, 0), 1, 0, 0, "einzel");
    pruefe("einzel iseite", ILesDaten, 0);

    resetPuls();
    bedient.delete();
    runde(mk(1, 0, 32'h10, 0), mk(0, 1, 32'h20, 32'hCAFEBABE), 2, 0, 0, "gleich");
    pruefe("gleich folge", {bedient[0][0], bedient[1][0]}, 2'b10);

    bedient.delete();
    for (int i = 0; i < 3; i++)
      runde(mk(1, 0, 32'h20, 0), mk(1, 0, 32'h5, 0), 1 + i, 0, 0, "fair");
    folge = '0;
    for (int i = 0; i < bedient.size() && i < 6; i++) folge = {folge[4:0], bedient[i][0]};
    pruefe("fair folge", folge, 6'b101010);

    runde(mk(1, 1, 32'h3, 32'h12345678), keine, 1, 0, 0, "konflikt");
    runde(mk(1, 0, 32'hABCD_8003, 0), keine, 3, 0, 0, "rueck");
    runde(keine, mk(1, 0, 32'h20, 0), 2, 0, 1, "falschpuls");
    runde(mk(0, 1, 32'h7, 32'h0BADF00D), keine, 1, 0, 1, "falschpuls w");

    runde(keine, mk(1, 0, 32'h5, 0), 1, 1, 0, "watchdog");
    pruefe("watchdog fehler", Fehler, 1);
    runde(mk(1, 0, 32'h5, 0), keine, 1, 0, 0, "nach watchdog");

    // Abandon an access that the RAM never answers.
    ramStumm = 1;
    DLesen = 1; DAdresse = 32'h7;
    repeat (3) @(negedge Clock);
    pruefe("mitten strobe", RAMLesen, 1);
    Reset = 1; DLesen = 0;
    @(negedge Clock);
    pruefe("mitten reset", {RAMLesen, RAMSchreiben, pulse, Fehler}, 7'b0);
    pruefe("mitten daten", DLesDaten, 0);
    Reset = 0; ramStumm = 0;
    refLetzterD = 0; refFehler = 0; refFrei = zyklus + 1;
    bedient.delete();
    runde(mk(1, 0, 32'h3, 0), mk(1, 0, 32'h7, 0), 1, 0, 0, "nach reset");
    pruefe("nach reset erster", bedient[0], 1);

    for (int i = 0; i < 40; i++) begin
      w = $urandom_range(1, 3);
      runde(w[0] ? zufall() : keine, w[1] ? zufall() : keine,
            $urandom_range(1, 4), 0, ($urandom_range(0, 7) == 0), "zufall");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
